// File: rtl/uart_pkg.sv
// Shared UART types: parity modes (also used by the receiver) and transmitter FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // ones_odd is the XOR of the data bits; EVEN sends it as-is, ODD sends its inverse.
  function automatic logic parity_bit(parity_e mode, logic ones_odd);
    return (mode == PARITY_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/strobe_div.sv
// Free-running divider: one-cycle strobe every DIV cycles, restarted from RESET_VAL by i_reset.
module strobe_div #(
  parameter int DIV       = 2,
  parameter int RESET_VAL = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_strobe
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= W'(RESET_VAL);
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign o_strobe = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, framed serial output with optional parity and 1-2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int      BAUD_DIV  = 3,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output tx_state_e            o_state
);

  // Handshake: a word is accepted on any cycle where i_valid && o_ready (o_ready is
  // forced low during reset); i_data is captured on that cycle only.

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 par_bit;
  logic                 strobe;
  logic                 div_clear;
  logic                 last_stop;
  logic                 handshake;

  // Divider is held cleared while idle so each frame's bit edges align to its handshake.
  assign div_clear = i_reset || (state == ST_IDLE);

  strobe_div #(
    .DIV      (BAUD_DIV),
    .RESET_VAL(0)
  ) u_baud (
    .i_clk   (i_clk),
    .i_reset (div_clear),
    .o_strobe(strobe)
  );

  assign last_stop = (state == ST_STOP) && strobe && (stop_cnt == LAST_STOP);
  assign o_ready   = !i_reset && ((state == ST_IDLE) || last_stop);
  assign handshake = i_valid && o_ready;
  assign o_state   = state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            state   <= ST_START;
            o_tx    <= 1'b0;
            o_busy  <= 1'b1;
            shreg   <= i_data;
            par_bit <= parity_bit(PARITY, ^i_data);
          end
        end
        ST_START: begin
          if (strobe) begin
            state   <= ST_DATA;
            o_tx    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (strobe) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                o_tx  <= par_bit;
              end else begin
                state    <= ST_STOP;
                o_tx     <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (strobe) begin
            state    <= ST_STOP;
            o_tx     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        ST_STOP: begin
          if (last_stop) begin
            // A word accepted in the last stop cycle starts its frame with no idle gap.
            if (handshake) begin
              state   <= ST_START;
              o_tx    <= 1'b0;
              shreg   <= i_data;
              par_bit <= parity_bit(PARITY, ^i_data);
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end else if (strobe) begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations driven side by side, checked against a frame-list model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BAUD = 4;
  localparam int NI   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      data [NI];
  logic [NI-1:0]   valid;
  logic [NI-1:0]   ready;
  logic [NI-1:0]   tx;
  logic [NI-1:0]   busy;
  tx_state_e       st [NI];

  // Per instance: parity 0=none 1=odd 2=even, and stop bit count.
  int cfg_par  [NI] = '{0, 2, 1, 0};
  int cfg_stop [NI] = '{1, 1, 1, 2};

  int        n_checks = 0;
  int        n_fail   = 0;
  logic [0:0] exp_q[$];
  logic      line_q[$];
  bit        capture = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_none (
    .i_clk(clk), .i_reset(reset), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_state(st[0]));
  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_even (
    .i_clk(clk), .i_reset(reset), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_state(st[1]));
  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)) u_odd (
    .i_clk(clk), .i_reset(reset), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_state(st[2]));
  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_stop2 (
    .i_clk(clk), .i_reset(reset), .i_data(data[3]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_state(st[3]));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit period, straight from the frame format.
  function automatic void build(int k, logic [7:0] d);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
    ones = $countones(d);
    if (cfg_par[k] == 2) exp_q.push_back(1'((ones % 2) == 1));
    if (cfg_par[k] == 1) exp_q.push_back(1'((ones % 2) == 0));
    for (int s = 0; s < cfg_stop[k]; s++) exp_q.push_back(1'b1);
  endfunction

  task automatic start(int k, logic [7:0] d);
    check($sformatf("ready_before_send k%0d", k), 32'(ready[k]), 32'd1);
    valid[k] = 1'b1;
    data[k]  = d;
  endtask

  task automatic check_frame(int k, logic [7:0] d, bit toggle, bit hold, logic [7:0] next_d);
    int len;
    build(k, d);
    len = exp_q.size() * BAUD;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      check($sformatf("tx k%0d d%02h c%0d", k, d, j), 32'(tx[k]), 32'(exp_q[(j-1)/BAUD]));
      check($sformatf("busy k%0d c%0d", k, j), 32'(busy[k]), 32'd1);
      check($sformatf("ready k%0d c%0d", k, j), 32'(ready[k]), 32'(j == len));
      if (capture) line_q.push_back(tx[k]);
      if (j == 1 && !hold) valid[k] = 1'b0;
      if (toggle) data[k] = 8'($urandom);
      if (j == len && hold) data[k] = next_d;
    end
  endtask

  task automatic idle_check(int k);
    @(negedge clk);
    check($sformatf("idle_tx k%0d", k), 32'(tx[k]), 32'd1);
    check($sformatf("idle_busy k%0d", k), 32'(busy[k]), 32'd0);
    check($sformatf("idle_ready k%0d", k), 32'(ready[k]), 32'd1);
    check($sformatf("idle_state k%0d", k), 32'(st[k]), 32'(ST_IDLE));
  endtask

  initial begin
    int i;
    int starts[$];
    logic [7:0] rx_bytes[$];
    logic [7:0] rb;
    int k;
    logic [7:0] d;

    reset = 1'b1;
    valid = '0;
    for (int n = 0; n < NI; n++) data[n] = 8'h00;
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      check($sformatf("rst_tx k%0d", n), 32'(tx[n]), 32'd1);
      check($sformatf("rst_busy k%0d", n), 32'(busy[n]), 32'd0);
      check($sformatf("rst_ready k%0d", n), 32'(ready[n]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int n = 0; n < NI; n++)
      check($sformatf("ready_after_rst k%0d", n), 32'(ready[n]), 32'd1);

    // Directed frames: 0xA5 with no/even/odd parity, 0x3C with two stop bits.
    for (int n = 0; n < 3; n++) begin
      start(n, 8'hA5);
      check_frame(n, 8'hA5, 1'b0, 1'b0, 8'h00);
      idle_check(n);
    end
    start(3, 8'h3C);
    check_frame(3, 8'h3C, 1'b0, 1'b0, 8'h00);
    idle_check(3);

    // Back-to-back 0x00 then 0xFF with valid held, decoded by a software receiver.
    line_q.delete();
    capture = 1'b1;
    start(0, 8'h00);
    check_frame(0, 8'h00, 1'b0, 1'b1, 8'hFF);
    check_frame(0, 8'hFF, 1'b0, 1'b0, 8'h00);
    capture = 1'b0;
    idle_check(0);
    i = 0;
    while (i + 40 <= line_q.size()) begin
      if (line_q[i] == 1'b0) begin
        starts.push_back(i);
        for (int b = 0; b < 8; b++) rb[b] = line_q[i + BAUD * (b + 1) + 2];
        check("rx_stop_bit", 32'(line_q[i + 38]), 32'd1);
        rx_bytes.push_back(rb);
        i += 40;
      end else begin
        i++;
      end
    end
    check("rx_frame_count", 32'(rx_bytes.size()), 32'd2);
    if (rx_bytes.size() == 2) begin
      check("rx_byte0", 32'(rx_bytes[0]), 32'h00);
      check("rx_byte1", 32'(rx_bytes[1]), 32'hFF);
      check("start_gap", 32'(starts[1] - starts[0]), 32'd40);
    end

    // Input churn mid-frame must not disturb the latched word.
    start(1, 8'h96);
    check_frame(1, 8'h96, 1'b1, 1'b0, 8'h00);
    idle_check(1);

    // Reset pulse during data bit 3, then a fresh 0x5A frame.
    start(0, 8'hC3);
    build(0, 8'hC3);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      check($sformatf("pre_abort_tx c%0d", j), 32'(tx[0]), 32'(exp_q[(j-1)/BAUD]));
      if (j == 1) valid[0] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_ready", 32'(ready[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("release_ready", 32'(ready[0]), 32'd1);
    check("release_tx", 32'(tx[0]), 32'd1);
    start(0, 8'h5A);
    check_frame(0, 8'h5A, 1'b0, 1'b0, 8'h00);
    idle_check(0);

    // Random words on random instances with random idle gaps and data churn.
    repeat (24) begin
      k = $urandom_range(0, NI - 1);
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) idle_check(k);
      start(k, d);
      check_frame(k, d, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
      idle_check(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 3: clock cycles per bit period; SHALL be >= 2.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; SHALL be 5..9.
REQ-003 Parameter PARITY, default PARITY_NONE (uart_pkg::parity_e): one of NONE, ODD, EVEN.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; SHALL be 1 or 2.
REQ-005 i_clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_data  input  DATA_BITS  word to transmit; sampled only on handshake.
REQ-008 i_valid  input  1  i_data is valid.
REQ-009 o_ready  output  1  block accepts a word this cycle.
REQ-010 o_tx  output  1  serial line, idle high.
REQ-011 o_busy  output  1  high while a frame is on the line.

Function
REQ-012 A handshake SHALL occur on any cycle where i_valid && o_ready && !i_reset; i_data SHALL be latched into an internal shift register on that cycle.
REQ-013 Frame order SHALL be: start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY != NONE, STOP_BITS stop bits (1).
REQ-014 The parity bit SHALL be XOR of the data bits for EVEN and its inverse for ODD.
REQ-015 The start bit SHALL appear on o_tx the cycle after the handshake; every bit SHALL be held exactly BAUD_DIV cycles.
REQ-016 Frame length SHALL be NBITS*BAUD_DIV cycles, where NBITS = 1 + DATA_BITS + (PARITY != NONE) + STOP_BITS.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; it SHALL skip PARITY when PARITY == NONE and advance only on the baud strobe.
REQ-018 o_ready SHALL be high in IDLE and in the final cycle of the last stop bit; it SHALL be low otherwise.
REQ-019 A handshake in the final stop-bit cycle SHALL start the next start bit on the following cycle with no idle gap; without a handshake the FSM SHALL return to IDLE.
REQ-020 o_busy SHALL be high from the cycle after the handshake through the last stop-bit cycle.
REQ-021 o_tx SHALL be driven from a register (glitch-free) and SHALL be 1 in IDLE.
REQ-022 Changes on i_data or i_valid mid-frame SHALL NOT affect the frame in flight.
REQ-023 The baud divider SHALL be held in reset in IDLE so that every frame starts phase-aligned to the handshake.

Reset
REQ-024 While i_reset is high: state = IDLE, o_tx = 1, o_busy = 0, o_ready = 0, baud divider cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame; o_tx SHALL be 1 on the next cycle, with no partial resumption.
REQ-026 o_ready SHALL be 1 on the first cycle after i_reset deasserts.

Structure
REQ-027 uart_pkg SHALL hold parity_e (PARITY_NONE, PARITY_ODD, PARITY_EVEN), which uart_rx parity extensions will share.
REQ-028 The bit timer SHALL be an instance of the existing strobe_div (DIV=BAUD_DIV, RESET_VAL=0).
REQ-029 A bit counter of width $clog2(DATA_BITS+1) SHALL track the data bits; no other sub-modules.

Verification (BAUD_DIV=4, DATA_BITS=8, STOP_BITS=1 unless noted)
REQ-030 PARITY=NONE, send 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_busy high for 40 cycles; o_ready high again at cycle 40.
REQ-031 PARITY=EVEN, send 0xA5 -> parity bit 0; PARITY=ODD -> parity bit 1; frame length 44 cycles.
REQ-032 i_valid held high with 0x00 then 0xFF -> second start bit immediately follows the first stop bit (exactly 40 cycles between start edges); loopback into uart_rx returns 0x00 then 0xFF.
REQ-033 STOP_BITS=2, send 0x3C -> o_tx high for 8 cycles after the last data bit; o_ready high only in the 8th of those cycles.
REQ-034 i_reset pulsed for 1 cycle during data bit 3 -> o_tx = 1 the next cycle; o_ready = 1 after release; a fresh 0x5A frame then transmits correctly.
REQ-035 i_data toggled every cycle mid-frame with i_valid low -> transmitted bits match the word latched at the handshake.
